pc_fetch: RTL

- Instruction-fetch front end, upstream of the pipeline controller.
- Owns the PC and runs a request/acknowledge handshake on the instruction bus.
- Raises the IF stall request while a fetch is outstanding.
- Obeys stall[5:0], flush and new_pc from the controller and branch redirects from ID; presents {pc, inst, valid, adel} to the IF/ID register.

---
 rtl/pc_fetch_pkg.sv | 15 +
 rtl/pc_fetch.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared constants and fetch-state encodings for the instruction-fetch front end.
package pc_fetch_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_HOLD    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, runs the req/ack instruction bus
// handshake and presents {pc, inst, valid, adel} to the IF/ID register.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_ack_i,
  input  logic [DATA_W-1:0] ibus_data_i,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              if_adel_o
);

  if_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_inst_buf, w_inst_buf_nxt;
  logic [ADDR_W-1:0] r_disc_addr, w_disc_addr_nxt;
  logic              w_misal;
  logic [ADDR_W-1:0] w_pc_adv;
  logic              w_unused;

  // Only the PC-stage stall bit matters here; IF/ID stalls are handled downstream.
  assign w_unused = ^stall[5:1];

  assign w_misal  = (r_pc[1:0] != 2'b00);
  assign w_pc_adv = branch_flag_i ? branch_target_address_i : (r_pc + ADDR_W'(4));

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_state     <= IF_IDLE;
      r_pc        <= RESET_PC;
      r_inst_buf  <= '0;
      r_disc_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_inst_buf  <= w_inst_buf_nxt;
      r_disc_addr <= w_disc_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_inst_buf_nxt  = r_inst_buf;
    w_disc_addr_nxt = r_disc_addr;
    ibus_req_o      = 1'b0;
    ibus_addr_o     = r_pc;
    stallreq_o      = NoStop;
    if_pc_o         = r_pc;
    if_inst_o       = '0;
    if_valid_o      = 1'b0;
    if_adel_o       = 1'b0;

    case (r_state)
      IF_IDLE: begin
        if_pc_o     = '0;
        w_state_nxt = IF_REQ;
      end
      IF_REQ: begin
        if (w_misal) begin
          // Misaligned PC never reaches the bus; the exception returns as a flush.
          if_valid_o = 1'b1;
          if_adel_o  = 1'b1;
          if (!stall[0]) w_pc_nxt = w_pc_adv;
        end else begin
          ibus_req_o = 1'b1;
          if (ibus_ack_i) begin
            if_valid_o = 1'b1;
            if_inst_o  = ibus_data_i;
            if (stall[0]) begin
              w_inst_buf_nxt = ibus_data_i;
              w_state_nxt    = IF_HOLD;
            end else begin
              w_pc_nxt = w_pc_adv;
            end
          end else begin
            stallreq_o = Stop;
          end
        end
      end
      IF_HOLD: begin
        if_valid_o = 1'b1;
        if_inst_o  = r_inst_buf;
        if (!stall[0]) begin
          w_pc_nxt    = w_pc_adv;
          w_state_nxt = IF_REQ;
        end
      end
      IF_DISCARD: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = r_disc_addr;
        stallreq_o  = Stop;
        if (ibus_ack_i) w_state_nxt = IF_REQ;
      end
      default: w_state_nxt = IF_IDLE;
    endcase

    if (flush) begin
      w_pc_nxt       = new_pc;
      w_inst_buf_nxt = '0;
      if_valid_o     = 1'b0;
      if_inst_o      = '0;
      if_adel_o      = 1'b0;
      if (r_state == IF_REQ && !w_misal && !ibus_ack_i) begin
        // The bus still owes us a response for the old address.
        w_state_nxt     = IF_DISCARD;
        w_disc_addr_nxt = r_pc;
      end else if (r_state != IF_DISCARD) begin
        w_state_nxt = IF_REQ;
      end
    end
  end

endmodule
